// File: rtl/gpio_result_drain.sv
// Captures core results on valid rising edges and drains them as 16-bit GPIO frames.
// Define DRAIN_PARITY_EN to append a 5th XOR parity word to every frame.
module gpio_result_drain #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      W,
  input  logic [23:0]      L,
  input  logic [1:0]       B,
  input  logic             valid,
  input  logic             gpio_ack,
  output logic [15:0]      gpio_out,
  output logic             gpio_stb,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] level,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
`ifdef DRAIN_PARITY_EN
  localparam logic [2:0] LAST = 3'd4;
`else
  localparam logic [2:0] LAST = 3'd3;
`endif

  typedef enum logic {IDLE, SEND} state_t;

  logic [57:0]      mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW-1:0]    rp_nx;
  logic [CNT_W-1:0] cnt;
  logic             valid_q;
  state_t           state;
  logic [2:0]       idx;
  logic             cap;
  logic             xfer;
  logic             pop;
  logic             wr;

  function automatic logic [15:0] word(
    input logic [57:0] r,
    input logic [2:0]  i
  );
    logic [15:0] w0, w1, w2, w3;
    w0 = {4'hA, 2'b00, r[57:56], r[55:48]};
    w1 = r[47:32];
    w2 = r[31:16];
    w3 = r[15:0];
    case (i)
      3'd0:    word = w0;
      3'd1:    word = w1;
      3'd2:    word = w2;
      3'd3:    word = w3;
`ifdef DRAIN_PARITY_EN
      3'd4:    word = w0 ^ w1 ^ w2 ^ w3;
`endif
      default: word = 16'h0;
    endcase
  endfunction

  assign rp_nx = rp + AW'(1);
  assign cap   = valid && !valid_q;
  assign xfer  = (state == SEND) && gpio_stb && gpio_ack;
  assign pop   = xfer && (idx == LAST);
  // A pop on the same edge frees the slot, so a full FIFO still accepts.
  assign wr    = cap && (!full || pop);
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  assign level = cnt;

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= {B, L, W};
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q  <= 1'b0;
      wp       <= '0;
      rp       <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
    end else begin
      valid_q <= valid;
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp_nx;
      if (cap && !wr) overflow <= 1'b1;
      case ({wr, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= 3'd0;
      gpio_out <= 16'h0;
      gpio_stb <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state    <= SEND;
            idx      <= 3'd0;
            gpio_out <= word(mem[rp], 3'd0);
            gpio_stb <= 1'b1;
          end
        end
        SEND: begin
          if (xfer) begin
            if (idx != LAST) begin
              idx      <= idx + 3'd1;
              gpio_out <= word(mem[rp], idx + 3'd1);
            end else if (cnt > CNT_W'(1)) begin
              idx      <= 3'd0;
              gpio_out <= word(mem[rp_nx], 3'd0);
            end else begin
              state    <= IDLE;
              idx      <= 3'd0;
              gpio_out <= 16'h0;
              gpio_stb <= 1'b0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_result_drain.sv
// Scoreboard bench for gpio_result_drain: expected words queued, monitor compares.
// Honors DRAIN_PARITY_EN for the 5-word frame variant.
module tb_gpio_result_drain;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;
`ifdef DRAIN_PARITY_EN
  localparam int NW = 5;
`else
  localparam int NW = 4;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [31:0]      W = '0;
  logic [23:0]      L = '0;
  logic [1:0]       B = '0;
  logic             valid = 1'b0;
  logic             gpio_ack = 1'b0;
  logic [15:0]      gpio_out;
  logic             gpio_stb;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] level;
  logic             overflow;

  logic [15:0] q [$];
  int checks = 0;
  int errors = 0;

  gpio_result_drain #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .W(W), .L(L), .B(B),
    .valid(valid), .gpio_ack(gpio_ack),
    .gpio_out(gpio_out), .gpio_stb(gpio_stb),
    .empty(empty), .full(full), .level(level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push_frame(input logic [31:0] w,
                                     input logic [23:0] l,
                                     input logic [1:0]  b);
    logic [15:0] f [5];
    f[0] = {4'hA, 2'b00, b, l[23:16]};
    f[1] = l[15:0];
    f[2] = w[31:16];
    f[3] = w[15:0];
    f[4] = f[0] ^ f[1] ^ f[2] ^ f[3];
    for (int i = 0; i < NW; i++) q.push_back(f[i]);
  endfunction

  always @(negedge clk) begin : mon
    logic [15:0] e;
    if (reset && gpio_stb && gpio_ack) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL word: got %h expected none", gpio_out);
      end else begin
        e = q.pop_front();
        if (gpio_out !== e) begin
          errors++;
          $display("FAIL word: got %h expected %h", gpio_out, e);
        end
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic pulse(input logic [31:0] w,
                       input logic [23:0] l,
                       input logic [1:0]  b);
    @(posedge clk);
    #1 W = w; L = l; B = b; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (!(q.size() == 0 && !gpio_stb && empty) && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    chk({name, " drain in time"}, 32'(n < 300), 32'd1);
    chk({name, " empty"}, 32'(empty), 32'd1);
    chk({name, " stb low"}, 32'(gpio_stb), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int peak;
    // 1: single frame
    do_reset();
    chk("rst gpio_out", 32'(gpio_out), 32'h0);
    chk("rst stb", 32'(gpio_stb), 32'd0);
    chk("rst empty", 32'(empty), 32'd1);
    chk("rst full", 32'(full), 32'd0);
    chk("rst level", 32'(level), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    gpio_ack = 1'b1;
    q.push_back(16'hA212);
    q.push_back(16'h3456);
    q.push_back(16'hDEAD);
    q.push_back(16'hBEEF);
`ifdef DRAIN_PARITY_EN
    q.push_back(16'hF606);
`endif
    pulse(32'hDEADBEEF, 24'h123456, 2'b10);
    wait_drain("t1");

    // 2: stall with ack low
    gpio_ack = 1'b0;
    push_frame(32'hDEADBEEF, 24'h123456, 2'b10);
    pulse(32'hDEADBEEF, 24'h123456, 2'b10);
    n = 0;
    while (!gpio_stb && n < 20) begin
      @(posedge clk);
      #1 n++;
    end
    chk("t2 stb rise", 32'(gpio_stb), 32'd1);
    repeat (5) begin
      chk("t2 stall out", 32'(gpio_out), 32'hA212);
      @(posedge clk);
      #1;
    end
    chk("t2 stall stb", 32'(gpio_stb), 32'd1);
    gpio_ack = 1'b1;
    wait_drain("t2");

    // 3: held valid captures once
    push_frame(32'h0BADF00D, 24'hA5A5A5, 2'b01);
    @(posedge clk);
    #1 W = 32'h0BADF00D; L = 24'hA5A5A5; B = 2'b01; valid = 1'b1;
    peak = 0;
    repeat (10) begin
      @(posedge clk);
      #1 if (int'(level) > peak) peak = int'(level);
    end
    valid = 1'b0;
    wait_drain("t3");
    chk("t3 level peak", 32'(peak), 32'd1);

    // 4: overflow
    gpio_ack = 1'b0;
    for (int k = 1; k <= 5; k++) pulse(32'(k), 24'h0, 2'b00);
    for (int k = 1; k <= 4; k++) push_frame(32'(k), 24'h0, 2'b00);
    chk("t4 full", 32'(full), 32'd1);
    chk("t4 level", 32'(level), 32'd4);
    chk("t4 overflow", 32'(overflow), 32'd1);
    gpio_ack = 1'b1;
    wait_drain("t4");
    chk("t4 overflow sticky", 32'(overflow), 32'd1);

    // 6: mid-frame reset, overflow still set from above
    q.push_back(16'hA30F);
    q.push_back(16'h0E0D);
    pulse(32'hCAFEF00D, 24'h0F0E0D, 2'b11);
    repeat (3) @(posedge clk);
    #1 gpio_ack = 1'b0; reset = 1'b0;
    chk("t6 w0 w1 sent", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
    chk("t6 stb", 32'(gpio_stb), 32'd0);
    chk("t6 out", 32'(gpio_out), 32'h0);
    chk("t6 level", 32'(level), 32'd0);
    chk("t6 empty", 32'(empty), 32'd1);
    chk("t6 overflow", 32'(overflow), 32'd0);
    reset = 1'b1;
    gpio_ack = 1'b1;
    push_frame(32'h12345678, 24'hFEDCBA, 2'b00);
    pulse(32'h12345678, 24'hFEDCBA, 2'b00);
    wait_drain("t6");

    // 5: push and pop on same edge while full
    do_reset();
    gpio_ack = 1'b0;
    for (int k = 0; k < 4; k++) pulse(32'h11 + 32'(k), 24'hABCDEF, 2'b01);
    for (int k = 0; k < 4; k++) push_frame(32'h11 + 32'(k), 24'hABCDEF, 2'b01);
    push_frame(32'h15, 24'hABCDEF, 2'b01);
    chk("t5 full", 32'(full), 32'd1);
    @(posedge clk);
    #1 gpio_ack = 1'b1;
    repeat (NW - 1) @(posedge clk);
    #1 W = 32'h15; L = 24'hABCDEF; B = 2'b01; valid = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    chk("t5 level", 32'(level), 32'd4);
    chk("t5 full after", 32'(full), 32'd1);
    chk("t5 overflow", 32'(overflow), 32'd0);
    wait_drain("t5");
    chk("t5 overflow end", 32'(overflow), 32'd0);

    chk("queue empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
